cplx_fwft_fifo: RTL and testbench

Parametrised complex-sample FIFO with first-word-fall-through, built in plain RTL with no vendor FIFO core. Real and imaginary parts share one pointer pair, so the block produces one full/empty status instead of two independently drifting ones. It also adds an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush and sticky overflow/underflow flags. It sits between R2 butterfly stages as the inter-stage delay/reorder buffer.

---
 rtl/r2fft_pkg.sv | 17 +
 rtl/cplx_fwft_fifo_if.sv | 39 +++
 rtl/cplx_fifo_mem.sv | 27 ++
 rtl/cplx_fwft_fifo.sv | 146 ++++++++++++++
 tb/tb_cplx_fwft_fifo.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/r2fft_pkg.sv
// Shared constants for the radix-2 FFT datapath: default sample width,
// default inter-stage buffer depth and a log2 helper for sizing pointers.
package r2fft_pkg;

    localparam int R2_WIDTH = 32'sd16;
    localparam int R2_DEPTH = 32'sd32;

    function automatic int clog2_f(input int value);
        int res;
        res = 32'sd0;
        for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 32'sd1) begin
            res = res + 32'sd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cplx_fwft_fifo_if.sv
// Handshake and status bundle of the complex FWFT FIFO; the producer/consumer
// side uses the master modport, the FIFO itself the slave modport.
interface cplx_fwft_fifo_if
    import r2fft_pkg::*;
#(
    parameter int WIDTH = R2_WIDTH,
    parameter int DEPTH = R2_DEPTH
);
    localparam int CW = clog2_f(DEPTH) + 32'sd1;

    logic                    flush;
    logic                    wr_en;
    logic signed [WIDTH-1:0] in_re;
    logic signed [WIDTH-1:0] in_im;
    logic                    rd_en;
    logic                    clr_err;
    logic signed [WIDTH-1:0] out_re;
    logic signed [WIDTH-1:0] out_im;
    logic                    empty;
    logic                    full;
    logic                    almost_empty;
    logic                    almost_full;
    logic [CW-1:0]           count;
    logic                    overflow;
    logic                    underflow;

    modport master (
        output flush, wr_en, in_re, in_im, rd_en, clr_err,
        input  out_re, out_im, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, in_re, in_im, rd_en, clr_err,
        output out_re, out_im, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );

endinterface

// File: rtl/cplx_fifo_mem.sv
// Dual-port register array for the complex FIFO: synchronous write,
// asynchronous read. Kept separate so a block-RAM variant can replace it.
module cplx_fifo_mem #(
    parameter int DW    = 32'sd32,
    parameter int DEPTH = 32'sd32,
    parameter int AW    = 32'sd5
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Store accepted writes; contents deliberately survive reset and flush
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cplx_fwft_fifo.sv
// First-word-fall-through FIFO for complex samples: one shared pointer pair for
// re/im, occupancy count, threshold flags, flush and sticky error flags.
module cplx_fwft_fifo
    import r2fft_pkg::*;
#(
    parameter int WIDTH     = R2_WIDTH,
    parameter int DEPTH     = R2_DEPTH,
    parameter int AFULL_TH  = DEPTH - 32'sd2,
    parameter int AEMPTY_TH = 32'sd2
) (
    input logic               clk,
    input logic               areset,
    cplx_fwft_fifo_if.slave   bus
);

    localparam int AW = clog2_f(DEPTH);
    localparam int CW = AW + 32'sd1;
    localparam int DW = 32'sd2 * WIDTH;

    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AFULL_TH);
    localparam logic [CW-1:0] CNT_AE   = CW'(AEMPTY_TH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          aempty_q, aempty_d;
    logic          afull_q, afull_d;

    logic          wa_s;
    logic          ra_s;
    logic          ovf_set_s;
    logic          udf_set_s;
    logic [DW-1:0] rdata_s;

    // A write into a full FIFO still lands when the head is popped in the same cycle
    assign wa_s      = !bus.flush && bus.wr_en && (!full_q || bus.rd_en);
    assign ra_s      = !bus.flush && bus.rd_en && !empty_q;
    assign ovf_set_s = !bus.flush && bus.wr_en && full_q && !bus.rd_en;
    assign udf_set_s = !bus.flush && bus.rd_en && empty_q;

    cplx_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (wa_s),
        .waddr_i (wr_ptr_q),
        .wdata_i ({bus.in_re, bus.in_im}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata_s)
    );

    // Next-state for pointers, occupancy, sticky flags and registered status
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = CNT_ZERO;
        end else begin
            if (wa_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (ra_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wa_s, ra_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        // A same-cycle set beats clr_err so no error event is ever lost
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (bus.clr_err) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (udf_set_s) begin
            udf_d = 1'b1;
        end else if (bus.clr_err) begin
            udf_d = 1'b0;
        end else begin
            udf_d = udf_q;
        end

        empty_d  = (count_d == CNT_ZERO);
        full_d   = (count_d == CNT_FULL);
        aempty_d = (count_d <= CNT_AE);
        afull_d  = (count_d >= CNT_AF);
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= CNT_ZERO;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            aempty_q <= aempty_d;
            afull_q  <= afull_d;
        end
    end

    assign bus.out_re       = empty_q ? {WIDTH{1'b0}} : $signed(rdata_s[DW-1:WIDTH]);
    assign bus.out_im       = empty_q ? {WIDTH{1'b0}} : $signed(rdata_s[WIDTH-1:0]);
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = aempty_q;
    assign bus.almost_full  = afull_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_cplx_fwft_fifo.sv
// Directed self-checking bench for cplx_fwft_fifo with DEPTH=32, WIDTH=16.
module tb_cplx_fwft_fifo;

    localparam int W = 16;
    localparam int D = 32;

    logic clk = 1'b0;
    logic areset;
    int   n_cmp = 0;
    int   n_err = 0;

    cplx_fwft_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

    cplx_fwft_fifo #(
        .WIDTH     (W),
        .DEPTH     (D),
        .AFULL_TH  (D - 2),
        .AEMPTY_TH (2)
    ) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic st(input string tag, input int cnt, input int emp, input int ful);
        chk({tag, " count"}, int'(bus.count), cnt);
        chk({tag, " empty"}, int'(bus.empty), emp);
        chk({tag, " full"},  int'(bus.full),  ful);
    endtask

    task automatic chk_out(input string tag, input int re, input int im);
        chk({tag, " out_re"}, int'(bus.out_re), re);
        chk({tag, " out_im"}, int'(bus.out_im), im);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        bus.in_re   = 16'sd0;
        bus.in_im   = 16'sd0;
    endtask

    task automatic push(input int re, input int im);
        bus.wr_en = 1'b1;
        bus.in_re = 16'(re);
        bus.in_im = 16'(im);
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        areset = 1'b1;
        idle();
        #1 areset = 1'b0;
        #2;
        st("reset", 0, 1, 0);
        chk("reset aempty", int'(bus.almost_empty), 1);
        chk("reset afull",  int'(bus.almost_full), 0);
        chk("reset ovf",    int'(bus.overflow), 0);
        chk("reset udf",    int'(bus.underflow), 0);
        chk_out("reset", 0, 0);
        @(negedge clk);
        areset = 1'b1;
        tick();

        // Single word fall-through and pop
        push(100, -100);
        chk_out("fwft", 100, -100);
        st("fwft", 1, 0, 0);
        pop();
        st("fwft pop", 0, 1, 0);
        chk_out("fwft pop", 0, 0);

        // Fill to full with threshold tracking, then overflow
        for (int i = 0; i < D; i++) begin
            push(i, -i);
            chk($sformatf("fill%0d count", i), int'(bus.count), i + 1);
            chk($sformatf("fill%0d afull", i), int'(bus.almost_full), (i + 1 >= 30) ? 1 : 0);
            chk($sformatf("fill%0d aempty", i), int'(bus.almost_empty), (i + 1 <= 2) ? 1 : 0);
        end
        st("full", 32, 0, 1);
        push(99, -99);
        chk("ovf set", int'(bus.overflow), 1);
        st("ovf", 32, 0, 1);
        chk_out("ovf head", 0, 0);
        for (int i = 0; i < D; i++) begin
            chk_out($sformatf("drain%0d", i), i, -i);
            pop();
        end
        st("drained", 0, 1, 0);
        chk("ovf sticky", int'(bus.overflow), 1);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        chk("ovf clr", int'(bus.overflow), 0);

        // Full FIFO streaming with simultaneous read/write across pointer wrap
        for (int j = 0; j < D; j++) begin
            push(1000 + j, -(1000 + j));
        end
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            bus.in_re = 16'(1032 + k);
            bus.in_im = 16'(-(1032 + k));
            chk_out($sformatf("stream%0d", k), 1000 + k, -(1000 + k));
            tick();
            chk($sformatf("stream%0d count", k), int'(bus.count), 32);
        end
        idle();
        chk("stream ovf", int'(bus.overflow), 0);
        for (int k = 0; k < D; k++) begin
            chk_out($sformatf("tail%0d", k), 1040 + k, -(1040 + k));
            pop();
        end
        st("tail", 0, 1, 0);

        // Empty FIFO with read and write together
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        bus.in_re = 16'sd7;
        bus.in_im = -16'sd7;
        tick();
        idle();
        chk("udf set", int'(bus.underflow), 1);
        st("udf", 1, 0, 0);
        chk_out("udf", 7, -7);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        chk("udf clr", int'(bus.underflow), 0);
        pop();
        bus.rd_en   = 1'b1;
        bus.clr_err = 1'b1;
        tick();
        idle();
        chk("udf set wins", int'(bus.underflow), 1);
        st("udf2", 0, 1, 0);

        // Flush with a concurrent write request
        for (int i = 0; i < 10; i++) begin
            push(200 + i, -(200 + i));
        end
        st("pre flush", 10, 0, 0);
        bus.flush = 1'b1;
        bus.wr_en = 1'b1;
        bus.in_re = 16'sd555;
        bus.in_im = -16'sd555;
        tick();
        idle();
        st("flush", 0, 1, 0);
        chk("flush udf", int'(bus.underflow), 1);
        chk("flush ovf", int'(bus.overflow), 0);
        chk_out("flush", 0, 0);
        push(9, -9);
        chk_out("post flush", 9, -9);
        push(10, -10);
        push(11, -11);
        st("pre reset", 3, 0, 0);

        // Asynchronous reset in the middle of a write burst
        bus.wr_en = 1'b1;
        bus.in_re = 16'sd12;
        bus.in_im = -16'sd12;
        #2 areset = 1'b0;
        #1;
        st("async rst", 0, 1, 0);
        chk("async rst aempty", int'(bus.almost_empty), 1);
        chk("async rst afull",  int'(bus.almost_full), 0);
        chk("async rst udf",    int'(bus.underflow), 0);
        chk("async rst ovf",    int'(bus.overflow), 0);
        chk_out("async rst", 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        areset = 1'b1;
        idle();
        tick();
        push(3, -3);
        chk_out("after rst", 3, -3);
        st("after rst", 1, 0, 0);
        pop();
        st("after rst pop", 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
